// File: rtl/clk_meas_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// clk_meas_pkg
// Shared definitions for the clock period meter:
//   - FSM state encoding (IDLE / ARM / MEAS) as plain localparam constants
//   - expected-window helper and a width-fit check used at elaboration
//   - absolute-difference helper for the period deviation check
// -----------------------------------------------------------------------------
package clk_meas_pkg;

  localparam int ST_W = 2;
  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ARM  = 2'd1;
  localparam state_t ST_MEAS = 2'd2;

  // Deviation arithmetic is done on a fixed 33-bit signed datapath, which
  // covers the CNT_W+1 bits needed for any accumulator up to 32 bits.
  localparam int ACC_W = 32;
  localparam int DEV_W = ACC_W + 1;

  // Expected number of clk_in cycles in one full window.
  function automatic longint exp_total(input int exp_period, input int win);
    return longint'(exp_period) * longint'(win);
  endfunction

  // True when value is representable as an unsigned number of 'width' bits.
  function automatic bit fits_width(input longint value, input int width);
    return (value >= 0) && (value < (longint'(1) << width));
  endfunction

  // |a - b| computed signed, one bit wider than the operands.
  function automatic logic [DEV_W-1:0] abs_diff(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b);
    logic signed [DEV_W-1:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? DEV_W'(-d) : DEV_W'(d);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sync_edge_det
// Brings an asynchronous level into the clk_in domain with a 2-flop
// synchronizer and flags its rising edges with a history flop.
// o_edge is high in the 3rd clk_in cycle after i_sig rises (setup met).
// Ports:
//   clk_in  - sampling clock
//   rst_n   - asynchronous active-low reset (all flops to 0)
//   i_sig   - asynchronous input level
//   o_edge  - one-cycle pulse on a synchronized rising edge
// -----------------------------------------------------------------------------
module sync_edge_det (
  input  logic clk_in,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_edge
);

  logic r_sync1;
  logic r_sync2;
  logic r_hist;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= i_sig;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign o_edge = r_sync2 & ~r_hist;

endmodule

// File: rtl/clk_period_meter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// clk_period_meter
// Measures the period of a slow asynchronous signal in clk_in cycles, summed
// over WIN rising-edge periods, and flags deviation from EXP_PERIOD*WIN by
// more than TOL, accumulator saturation, and loss of the signal.
// Ports:
//   clk_in      - the only clock
//   rst_n       - asynchronous active-low reset
//   en          - measurement enable (sync to clk_in); low forces IDLE
//   sig_in      - signal under test (asynchronous)
//   meas_valid  - one-cycle pulse: meas_cycles/period_err/overflow updated
//   meas_cycles - cycles spanned by the last complete window (held)
//   period_err  - last result outside tolerance
//   overflow    - last window saturated the accumulator
//   timeout     - one-cycle pulse after TIMEOUT cycles without an edge
//   dbg_state   - current FSM state (ST_IDLE / ST_ARM / ST_MEAS)
// meas_valid is a strobe without back-pressure: there is no ready, a result
// is presented for exactly one cycle and the data outputs hold afterwards.
// -----------------------------------------------------------------------------
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int WIN        = 8,
  parameter int EXP_PERIOD = 10,
  parameter int TOL        = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_cycles,
  output logic             period_err,
  output logic             overflow,
  output logic             timeout,
  output state_t           dbg_state
);

  localparam int               EW        = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int               TW        = $clog2(TIMEOUT + 1);
  localparam longint           EXP_TOT   = exp_total(EXP_PERIOD, WIN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [EW-1:0]    EDGE_LAST = EW'(WIN - 1);
  localparam logic [TW-1:0]    TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [ACC_W-1:0] EXP_VEC   = ACC_W'(EXP_TOT);
  localparam logic [DEV_W-1:0] TOL_VEC   = DEV_W'(TOL);

  // Elaboration-time parameter sanity.
  if (!fits_width(EXP_TOT, CNT_W)) begin : g_bad_exp
    $error("EXP_PERIOD*WIN does not fit in CNT_W bits");
  end
  if (CNT_W < 1 || CNT_W > ACC_W) begin : g_bad_cnt_w
    $error("CNT_W must be in 1..32");
  end
  if (WIN < 1) begin : g_bad_win
    $error("WIN must be at least 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_t           r_state;
  logic [CNT_W-1:0] r_cyc_cnt;
  logic [EW-1:0]    r_edge_cnt;
  logic [TW-1:0]    r_to_cnt;
  logic             r_ovf;
  logic             r_meas_valid;
  logic [CNT_W-1:0] r_meas_cycles;
  logic             r_period_err;
  logic             r_overflow;
  logic             r_timeout;

  logic             w_edge;
  logic             w_sat;
  logic [CNT_W-1:0] w_cyc_next;
  logic             w_to_hit;
  logic [DEV_W-1:0] w_dev;
  logic             w_err;

  sync_edge_det u_sync (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .i_sig  (sig_in),
    .o_edge (w_edge)
  );

  // Saturating cycle count; reaching the ceiling while still counting marks
  // the window as overflowed.
  assign w_sat      = (r_cyc_cnt == CNT_MAX);
  assign w_cyc_next = w_sat ? r_cyc_cnt : r_cyc_cnt + CNT_W'(1);

  // Timeout fires on the TIMEOUT-th consecutive cycle without an edge.
  assign w_to_hit   = (r_to_cnt == TO_LAST);

  assign w_dev      = abs_diff(ACC_W'(r_cyc_cnt), EXP_VEC);
  assign w_err      = (w_dev > TOL_VEC);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cyc_cnt     <= '0;
      r_edge_cnt    <= '0;
      r_to_cnt      <= '0;
      r_ovf         <= 1'b0;
      r_meas_valid  <= 1'b0;
      r_meas_cycles <= '0;
      r_period_err  <= 1'b0;
      r_overflow    <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;
      r_timeout    <= 1'b0;
      if (!en) begin
        // Enable has top priority: even a closing edge is dropped here.
        r_state    <= ST_IDLE;
        r_cyc_cnt  <= '0;
        r_edge_cnt <= '0;
        r_to_cnt   <= '0;
        r_ovf      <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_ARM;
          end
          ST_ARM: begin
            if (w_edge) begin
              r_cyc_cnt  <= CNT_W'(1);
              r_edge_cnt <= '0;
              r_to_cnt   <= '0;
              r_ovf      <= 1'b0;
              r_state    <= ST_MEAS;
            end else if (w_to_hit) begin
              r_timeout <= 1'b1;
              r_to_cnt  <= '0;
            end else begin
              r_to_cnt <= r_to_cnt + TW'(1);
            end
          end
          ST_MEAS: begin
            if (w_edge) begin
              r_to_cnt <= '0;
              if (r_edge_cnt == EDGE_LAST) begin
                // Close this window and open the next on the same edge.
                r_meas_valid  <= 1'b1;
                r_meas_cycles <= r_cyc_cnt;
                r_overflow    <= r_ovf;
                r_period_err  <= w_err;
                r_cyc_cnt     <= CNT_W'(1);
                r_edge_cnt    <= '0;
                r_ovf         <= 1'b0;
              end else begin
                r_edge_cnt <= r_edge_cnt + EW'(1);
                r_cyc_cnt  <= w_cyc_next;
                if (w_sat) r_ovf <= 1'b1;
              end
            end else if (w_to_hit) begin
              // Signal lost: drop the partial window, results stay as they are.
              r_timeout  <= 1'b1;
              r_to_cnt   <= '0;
              r_cyc_cnt  <= '0;
              r_edge_cnt <= '0;
              r_ovf      <= 1'b0;
              r_state    <= ST_ARM;
            end else begin
              r_to_cnt  <= r_to_cnt + TW'(1);
              r_cyc_cnt <= w_cyc_next;
              if (w_sat) r_ovf <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign meas_valid  = r_meas_valid;
  assign meas_cycles = r_meas_cycles;
  assign period_err  = r_period_err;
  assign overflow    = r_overflow;
  assign timeout     = r_timeout;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_clk_period_meter.sv
`timescale 1ns/1ps
module tb_clk_period_meter;
  import clk_meas_pkg::*;

  // ---------------------------------------------------------------- signals
  logic        clk_in;
  logic        rst_n;
  logic        en;
  logic        sig_in;

  logic        meas_valid;
  logic [15:0] meas_cycles;
  logic        period_err;
  logic        overflow;
  logic        timeout;
  state_t      dbg_state;

  logic        ov_valid;
  logic [5:0]  ov_cycles;
  logic        ov_err;
  logic        ov_ovf;
  logic        ov_timeout;
  state_t      ov_state;

  int          n_checks = 0;
  int          n_errors = 0;

  bit          sig_run;
  realtime     sig_per;
  realtime     t_hi;
  realtime     t_lo;

  // ---------------------------------------------------------------- DUTs
  clk_period_meter u_dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .en          (en),
    .sig_in      (sig_in),
    .meas_valid  (meas_valid),
    .meas_cycles (meas_cycles),
    .period_err  (period_err),
    .overflow    (overflow),
    .timeout     (timeout),
    .dbg_state   (dbg_state)
  );

  // Narrow accumulator: an 80-cycle window saturates at 63.
  clk_period_meter #(
    .CNT_W      (6),
    .WIN        (8),
    .EXP_PERIOD (5),
    .TOL        (2),
    .TIMEOUT    (1024)
  ) u_ovf (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .en          (en),
    .sig_in      (sig_in),
    .meas_valid  (ov_valid),
    .meas_cycles (ov_cycles),
    .period_err  (ov_err),
    .overflow    (ov_ovf),
    .timeout     (ov_timeout),
    .dbg_state   (ov_state)
  );

  // ---------------------------------------------------------------- clock / reset
  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Signal generator: a new period length is picked up at each rising edge.
  // Starting from idle it rises 2.3 ns after a clk_in posedge so transitions
  // never coincide with a sampling edge.
  initial begin
    sig_in = 1'b0;
    forever begin
      if (sig_run) begin
        t_hi   = sig_per / 2.0;
        t_lo   = sig_per - t_hi;
        sig_in = 1'b1;
        #(t_hi);
        sig_in = 1'b0;
        #(t_lo);
      end else begin
        sig_in = 1'b0;
        @(posedge clk_in);
        #2.3;
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- scoreboard
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- driver tasks
  task automatic wait_valid(input bit sel, input int budget, output bit got, output int waited);
    got    = 1'b0;
    waited = 0;
    while (!got && waited < budget) begin
      @(negedge clk_in);
      waited++;
      got = sel ? ov_valid : meas_valid;
    end
  endtask

  task automatic wait_to(input int budget, output bit got, output int waited, output int n_valid);
    got     = 1'b0;
    waited  = 0;
    n_valid = 0;
    while (!got && waited < budget) begin
      @(negedge clk_in);
      waited++;
      got = timeout;
      if (meas_valid) n_valid++;
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    bit got;
    int waited;
    int n_valid;

    rst_n   = 1'b0;
    en      = 1'b0;
    sig_run = 1'b0;
    sig_per = 100.0;
    repeat (3) @(negedge clk_in);

    // Reset values
    chk("rst_valid",  meas_valid,  0);
    chk("rst_cycles", meas_cycles, 0);
    chk("rst_err",    period_err,  0);
    chk("rst_ovf",    overflow,    0);
    chk("rst_to",     timeout,     0);
    chk("rst_state",  dbg_state,   ST_IDLE);

    rst_n = 1'b1;
    @(negedge clk_in);
    chk("idle_no_en", dbg_state, ST_IDLE);

    en      = 1'b1;
    sig_run = 1'b1;
    @(negedge clk_in);
    chk("armed", dbg_state, ST_ARM);

    // Nominal: 100 ns period, 8 periods -> 80 cycles
    wait_valid(0, 300, got, waited);
    chk("nom1_seen", got, 1);
    chk("nom1_cycles", meas_cycles, 80);
    chk("nom1_err", period_err, 0);
    chk("nom1_ovf", overflow, 0);
    wait_valid(0, 300, got, waited);
    chk("nom2_seen", got, 1);
    chk("nom2_interval", waited, 80);
    chk("nom2_cycles", meas_cycles, 80);

    // Narrow instance saturates
    wait_valid(1, 300, got, waited);
    chk("sat_seen", got, 1);
    chk("sat_cycles", ov_cycles, 63);
    chk("sat_ovf", ov_ovf, 1);
    chk("sat_err", ov_err, 1);

    // 110 ns period -> 88 cycles, outside tolerance. First window is mixed.
    wait_valid(0, 300, got, waited);
    sig_per = 110.0;
    wait_valid(0, 300, got, waited);
    wait_valid(0, 300, got, waited);
    chk("slow_seen", got, 1);
    chk("slow_cycles", meas_cycles, 88);
    chk("slow_err", period_err, 1);
    chk("slow_ovf", overflow, 0);

    // 102.5 ns period -> 820 ns window = 82 cycles, deviation 2 == TOL
    sig_per = 102.5;
    wait_valid(0, 300, got, waited);
    for (int i = 0; i < 2; i++) begin
      wait_valid(0, 300, got, waited);
      chk("frac_seen", got, 1);
      chk("frac_cycles", meas_cycles, 82);
      chk("frac_err", period_err, 0);
    end

    // Back to nominal, then stop the signal
    sig_per = 100.0;
    wait_valid(0, 300, got, waited);
    wait_valid(0, 300, got, waited);
    chk("renom_cycles", meas_cycles, 80);
    sig_run = 1'b0;

    wait_to(1400, got, waited, n_valid);
    chk("to1_seen", got, 1);
    chk("to1_state", dbg_state, ST_ARM);
    chk("to1_keep_cycles", meas_cycles, 80);
    chk("to1_no_valid", n_valid, 0);
    wait_to(1100, got, waited, n_valid);
    chk("to2_seen", got, 1);
    chk("to2_interval", waited, 1024);
    chk("to2_no_valid", n_valid, 0);
    @(negedge clk_in);
    chk("to_pulse_width", timeout, 0);

    // Restart: first result is a clean full window
    sig_run = 1'b1;
    wait_valid(0, 300, got, waited);
    chk("restart_seen", got, 1);
    chk("restart_cycles", meas_cycles, 80);
    chk("restart_err", period_err, 0);

    // Enable drop exactly on the next closing edge (80 cycles later)
    repeat (79) @(negedge clk_in);
    en = 1'b0;
    @(negedge clk_in);
    chk("endrop_no_valid", meas_valid, 0);
    chk("endrop_state", dbg_state, ST_IDLE);
    en = 1'b1;
    // Arm on the edge 10 cycles later, close 80 cycles after that
    wait_valid(0, 300, got, waited);
    chk("reen_seen", got, 1);
    chk("reen_interval", waited, 90);
    chk("reen_cycles", meas_cycles, 80);

    // Reset mid-window
    repeat (30) @(negedge clk_in);
    rst_n = 1'b0;
    #1;
    chk("mrst_cycles", meas_cycles, 0);
    chk("mrst_valid", meas_valid, 0);
    chk("mrst_state", dbg_state, ST_IDLE);
    chk("mrst_ovf_inst", ov_cycles, 0);
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    wait_valid(0, 300, got, waited);
    chk("post_rst_seen", got, 1);
    chk("post_rst_cycles", meas_cycles, 80);
    chk("post_rst_err", period_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
